d3s_phase_gen: RTL

- Parallel NCO phase generator producing four consecutive phase samples per clock for the downstream sine LUT / DAC stage.
- Holds a wide phase accumulator advanced by 4×FTW per cycle, derives the four per-sample phases, applies a phase offset and truncates to 14 bits.
- Supports atomic frequency-tuning-word updates via valid/ready handshake and phase zeroing on an external sync pulse (WR tick).

---
 rtl/d3s_phase_gen_if.sv | 23 ++
 rtl/d3s_phase_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/d3s_phase_gen_if.sv
// FTW handshake and four-sample phase bus between the NCO phase generator and its neighbours.
// The master side supplies tuning word and offset; the slave side returns the phase words.
interface d3s_phase_gen_if #(
  parameter int unsigned g_acc_bits   = 32,
  parameter int unsigned g_phase_bits = 14
);
  logic [g_acc_bits-1:0]     ftw;
  logic                      ftw_valid;
  logic                      ftw_ready;
  logic [g_phase_bits-1:0]   phase_offset;
  logic [4*g_phase_bits-1:0] phase_divided;
  logic                      phase_valid;

  modport master (
    output ftw, ftw_valid, phase_offset,
    input  ftw_ready, phase_divided, phase_valid
  );

  modport slave (
    input  ftw, ftw_valid, phase_offset,
    output ftw_ready, phase_divided, phase_valid
  );
endinterface

// File: rtl/d3s_phase_gen.sv
// Parallel NCO phase generator: four consecutive phase samples per clock, with atomic FTW
// updates, sync-pulse phase zeroing and a static phase offset.
module d3s_phase_gen #(
  parameter int unsigned g_acc_bits   = 32,
  parameter int unsigned g_phase_bits = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  output logic              running_o,
  d3s_phase_gen_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;
  typedef logic [g_acc_bits-1:0]   acc_t;
  typedef logic [g_phase_bits-1:0] ph_t;

  state_e state_q, state_d;
  acc_t   acc_q, acc_d;
  acc_t   hold_q, hold_d;
  acc_t   shadow_q [4];
  acc_t   shadow_d [4];
  acc_t   mult_q [4];
  acc_t   mult_d [4];
  logic   calc_q, calc_d;
  logic   swap_q, swap_d;
  logic   ready_q, ready_d;
  acc_t   s_q [4];
  acc_t   s_d [4];
  logic   v1_q, v1_d;
  logic   v2_q, v2_d;
  ph_t    p_q [4];
  ph_t    p_d [4];
  logic   accept;
  logic   running;

  // FTW: capture at accept, build F..4F one edge later, swap them in the edge after that.
  always_comb begin
    accept  = bus.ftw_valid & ready_q;
    hold_d  = accept ? bus.ftw : hold_q;
    calc_d  = accept;
    swap_d  = calc_q;
    ready_d = ~(accept | calc_q);
    for (int k = 0; k < 4; k++) begin
      shadow_d[k] = shadow_q[k];
      mult_d[k]   = swap_q ? shadow_q[k] : mult_q[k];
    end
    if (calc_q) begin
      shadow_d[0] = hold_q;
      shadow_d[1] = hold_q << 1;
      shadow_d[2] = (hold_q << 1) + hold_q;
      shadow_d[3] = hold_q << 2;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        acc_d = '0;
        if (en_i) state_d = StArmed;
      end
      StArmed: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (sync_i) begin
          state_d = StRun;
          acc_d   = '0;
        end
      end
      StRun: begin
        // Disable takes priority over a coincident resync.
        if (!en_i) begin
          state_d = StIdle;
          acc_d   = '0;
        end else if (sync_i) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + mult_q[3];
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
      end
    endcase
  end

  assign running = (state_q == StRun);

  always_comb begin
    v1_d = running;
    v2_d = v1_q;
    for (int k = 0; k < 4; k++) begin
      s_d[k] = s_q[k];
      p_d[k] = p_q[k];
    end
    if (running) begin
      s_d[0] = acc_q;
      for (int k = 1; k < 4; k++) s_d[k] = acc_q + mult_q[k-1];
    end
    if (v1_q) begin
      for (int k = 0; k < 4; k++) p_d[k] = s_q[k][g_acc_bits-1 -: g_phase_bits] + bus.phase_offset;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      hold_q  <= '0;
      calc_q  <= 1'b0;
      swap_q  <= 1'b0;
      ready_q <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        shadow_q[k] <= '0;
        mult_q[k]   <= '0;
        s_q[k]      <= '0;
        p_q[k]      <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      calc_q  <= calc_d;
      swap_q  <= swap_d;
      ready_q <= ready_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      for (int k = 0; k < 4; k++) begin
        shadow_q[k] <= shadow_d[k];
        mult_q[k]   <= mult_d[k];
        s_q[k]      <= s_d[k];
        p_q[k]      <= p_d[k];
      end
    end
  end

  assign running_o         = running;
  assign bus.ftw_ready     = ready_q;
  assign bus.phase_valid   = v2_q;
  assign bus.phase_divided = {p_q[3], p_q[2], p_q[1], p_q[0]};

endmodule
